dyn_phase_ctrl: RTL and testbench

Sequencer for the PLL dynamic phase-shift port on the CLK50M (PLL scan clock) domain. It accepts one command at a time: PLL counter select, direction and number of steps. For each step it drives the phasestep / phasecounterselect / phaseupdown handshake, waits for the PLL's phasedone response and counts completed steps. It sits between the Avalon phase register block (which supplies commands) and the PLL, replacing a single free-running enable pulse with a checked, multi-step, timeout-protected sequence.

---
 rtl/dyn_phase_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dyn_phase_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dyn_phase_ctrl.sv
// PLL dynamic phase-shift sequencer: runs one multi-step phasestep/phasedone
// handshake per accepted command, with a per-wait timeout and step counting.
`timescale 1ns/1ps
module dyn_phase_ctrl #(
  parameter int P_STEP_W    = 8,
  parameter int P_STEP_HOLD = 2,
  parameter int P_TIMEOUT   = 255
) (
  input  logic                CLK50M,
  input  logic                RESET,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [3:0]          CMD_COUNTER,
  input  logic                CMD_UPDOWN,
  input  logic [P_STEP_W-1:0] CMD_STEPS,
  output logic [3:0]          PLL_PHASECOUNTERSELECT,
  output logic                PLL_PHASEUPDOWN,
  output logic                PLL_PHASESTEP,
  input  logic                PLL_PHASEDONE,
  output logic                BUSY,
  output logic                DONE_PLS,
  output logic                ERR_TIMEOUT,
  output logic [P_STEP_W-1:0] STEPS_DONE
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STEP      = 3'd2,
    ST_WAIT_LOW  = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  // One shared 8-bit timer: hold counter in STEP, timeout counter in the wait states.
  localparam logic [7:0] TMR_TIMEOUT_LAST = 8'(P_TIMEOUT - 1);
  localparam logic [7:0] TMR_HOLD_LAST    = 8'(P_STEP_HOLD - 1);
  localparam logic [P_STEP_W-1:0] STEP_ONE = {{(P_STEP_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [7:0]          tmr_r, tmr_s;
  logic [P_STEP_W-1:0] steps_r, steps_s;
  logic [P_STEP_W-1:0] done_cnt_r, done_cnt_s;
  logic [3:0]          sel_r, sel_s;
  logic                ud_r, ud_s;
  logic                step_r;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic                ready_r, ready_s;
  logic                tmo_hit_s;

  // Next-state and next-output logic for the handshake sequencer.
  always_comb begin
    state_s    = state_r;
    tmr_s      = tmr_r + 8'd1;
    steps_s    = steps_r;
    done_cnt_s = done_cnt_r;
    sel_s      = sel_r;
    ud_s       = ud_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = err_r;
    tmo_hit_s  = (tmr_r == TMR_TIMEOUT_LAST);

    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        tmr_s  = 8'd0;
        if (CMD_VALID && ready_r) begin
          sel_s      = CMD_COUNTER;
          ud_s       = CMD_UPDOWN;
          steps_s    = CMD_STEPS;
          done_cnt_s = '0;
          err_s      = 1'b0;
          if (CMD_STEPS == '0) begin
            done_s = 1'b1;
          end else begin
            state_s = ST_SETUP;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (PLL_PHASEDONE) begin
          state_s = ST_STEP;
          tmr_s   = 8'd0;
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_STEP: begin
        if (tmr_r == TMR_HOLD_LAST) begin
          state_s = ST_WAIT_LOW;
          tmr_s   = 8'd0;
        end else begin
          state_s = ST_STEP;
        end
      end
      ST_WAIT_LOW: begin
        if (!PLL_PHASEDONE) begin
          state_s = ST_WAIT_HIGH;
          tmr_s   = 8'd0;
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          state_s = ST_WAIT_LOW;
        end
      end
      ST_WAIT_HIGH: begin
        if (PLL_PHASEDONE) begin
          // Saturating count; it can never pass the latched step count.
          if (done_cnt_r < steps_r) begin
            done_cnt_s = done_cnt_r + STEP_ONE;
          end else begin
            done_cnt_s = done_cnt_r;
          end
          if (done_cnt_s == steps_r) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = ST_GAP;
          end
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          state_s = ST_WAIT_HIGH;
        end
      end
      ST_GAP: begin
        state_s = ST_STEP;
        tmr_s   = 8'd0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        tmr_s   = 8'd0;
      end
    endcase

    ready_s = (state_s == ST_IDLE);
  end

  // State and registered-output update; phasestep follows the STEP state one cycle later.
  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      tmr_r      <= 8'd0;
      steps_r    <= '0;
      done_cnt_r <= '0;
      sel_r      <= 4'b0000;
      ud_r       <= 1'b0;
      step_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_s;
      tmr_r      <= tmr_s;
      steps_r    <= steps_s;
      done_cnt_r <= done_cnt_s;
      sel_r      <= sel_s;
      ud_r       <= ud_s;
      step_r     <= (state_r == ST_STEP);
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      ready_r    <= ready_s;
    end
  end

  assign CMD_READY              = ready_r;
  assign PLL_PHASECOUNTERSELECT = sel_r;
  assign PLL_PHASEUPDOWN        = ud_r;
  assign PLL_PHASESTEP          = step_r;
  assign BUSY                   = busy_r;
  assign DONE_PLS               = done_r;
  assign ERR_TIMEOUT            = err_r;
  assign STEPS_DONE             = done_cnt_r;

endmodule

// File: tb/tb_dyn_phase_ctrl.sv
// Randomized bench for dyn_phase_ctrl: a reactive PLL responder plus a
// transaction-level timing model predicting every output cycle by cycle.
`timescale 1ns/1ps
module tb_dyn_phase_ctrl;

  localparam int STEP_W = 8;
  localparam int HOLD   = 2;
  localparam int TMO    = 255;

  logic              CLK50M = 1'b0;
  logic              RESET = 1'b1;
  logic              CMD_VALID = 1'b0;
  logic              CMD_READY;
  logic [3:0]        CMD_COUNTER = 4'd0;
  logic              CMD_UPDOWN = 1'b0;
  logic [STEP_W-1:0] CMD_STEPS = '0;
  logic [3:0]        PLL_PHASECOUNTERSELECT;
  logic              PLL_PHASEUPDOWN;
  logic              PLL_PHASESTEP;
  logic              PLL_PHASEDONE = 1'b1;
  logic              BUSY;
  logic              DONE_PLS;
  logic              ERR_TIMEOUT;
  logic [STEP_W-1:0] STEPS_DONE;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 CLK50M = ~CLK50M;

  dyn_phase_ctrl #(
    .P_STEP_W   (STEP_W),
    .P_STEP_HOLD(HOLD),
    .P_TIMEOUT  (TMO)
  ) dut (
    .CLK50M                (CLK50M),
    .RESET                 (RESET),
    .CMD_VALID             (CMD_VALID),
    .CMD_READY             (CMD_READY),
    .CMD_COUNTER           (CMD_COUNTER),
    .CMD_UPDOWN            (CMD_UPDOWN),
    .CMD_STEPS             (CMD_STEPS),
    .PLL_PHASECOUNTERSELECT(PLL_PHASECOUNTERSELECT),
    .PLL_PHASEUPDOWN       (PLL_PHASEUPDOWN),
    .PLL_PHASESTEP         (PLL_PHASESTEP),
    .PLL_PHASEDONE         (PLL_PHASEDONE),
    .BUSY                  (BUSY),
    .DONE_PLS              (DONE_PLS),
    .ERR_TIMEOUT           (ERR_TIMEOUT),
    .STEPS_DONE            (STEPS_DONE)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_step"},  int'(PLL_PHASESTEP), 0);
    check_eq({tag, "_busy"},  int'(BUSY), 0);
    check_eq({tag, "_done"},  int'(DONE_PLS), 0);
    check_eq({tag, "_ready"}, int'(CMD_READY), 1);
    check_eq({tag, "_sdone"}, int'(STEPS_DONE), 0);
    check_eq({tag, "_sel"},   int'(PLL_PHASECOUNTERSELECT), 0);
    check_eq({tag, "_ud"},    int'(PLL_PHASEUPDOWN), 0);
    check_eq({tag, "_err"},   int'(ERR_TIMEOUT), 0);
  endtask

  // Issue one command (called just after a posedge) and check every cycle to completion.
  // Edge k counts posedges after acceptance. Step i: phasestep rises after edge p[i],
  // phasedone goes low a[i] edges later and returns high b[i] edges after that, so the
  // step completes on edge d[i] = p[i]+a[i]+b[i]+1 and the next rise is d[i]+2.
  // A step whose phasedone never falls times out on edge p[i]+HOLD+TMO-1.
  task automatic run_cmd(input int ctr, input int ud, input int steps, input int stuck,
                         input int a_fix, input int b_fix, input bit do_busy, input bit do_rst);
    int a[8]; int b[8]; int p[8]; int d[8];
    int ncomp, npl, done_e, busy_at, rst_at, si, cur_p, exp_ps, exp_sd;
    bit tmo;
    logic ps_prev;

    tmo   = (stuck < steps);
    ncomp = tmo ? stuck : steps;
    npl   = tmo ? stuck + 1 : steps;
    for (int i = 0; i < 8; i++) begin
      a[i] = (a_fix > 0) ? a_fix : int'($urandom_range(1, 4));
      b[i] = (b_fix > 0) ? b_fix : int'($urandom_range(1, 6));
      p[i] = 0;
      d[i] = 0;
    end
    done_e = 0;
    for (int i = 0; i < npl; i++) begin
      p[i] = (i == 0) ? 2 : d[i-1] + 2;
      if (i < ncomp) begin
        d[i]   = p[i] + a[i] + b[i] + 1;
        done_e = d[i];
      end else begin
        done_e = p[i] + HOLD + TMO - 1;
      end
    end
    busy_at = do_busy ? p[0] + a[0] + 1 : -1;
    rst_at  = do_rst ? p[1] : -1;

    CMD_COUNTER = 4'(ctr);
    CMD_UPDOWN  = 1'(ud);
    CMD_STEPS   = STEP_W'(steps);
    CMD_VALID   = 1'b1;
    @(negedge CLK50M);
    check_eq("ready_pre", int'(CMD_READY), 1);
    @(posedge CLK50M); #1;
    CMD_VALID = 1'b0;

    si = 0; cur_p = -1; ps_prev = 1'b0;
    for (int k = 0; k <= done_e; k++) begin
      if (k > 0) begin @(posedge CLK50M); #1; end
      if (cur_p >= 0) begin
        if (k == cur_p + a[si]) PLL_PHASEDONE = 1'b0;
        if (k == cur_p + a[si] + b[si]) begin
          PLL_PHASEDONE = 1'b1;
          si++;
          cur_p = -1;
        end
      end
      if (k == busy_at) begin
        CMD_VALID   = 1'b1;
        CMD_COUNTER = ~CMD_COUNTER;
        CMD_UPDOWN  = ~CMD_UPDOWN;
        CMD_STEPS   = STEP_W'(3);
      end else begin
        CMD_VALID = 1'b0;
      end
      if (k == rst_at) begin
        RESET = 1'b1;
        @(posedge CLK50M); #1;
        RESET = 1'b0;
        PLL_PHASEDONE = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge CLK50M);
          check_idle_outputs("midrst");
          @(posedge CLK50M); #1;
        end
        return;
      end
      @(negedge CLK50M);
      if (PLL_PHASESTEP && !ps_prev && si < ncomp) cur_p = k;
      ps_prev = PLL_PHASESTEP;
      exp_ps = 0;
      exp_sd = 0;
      for (int i = 0; i < npl; i++) if (k >= p[i] && k < p[i] + HOLD) exp_ps = 1;
      for (int i = 0; i < ncomp; i++) if (d[i] <= k) exp_sd++;
      check_eq("phasestep", int'(PLL_PHASESTEP), exp_ps);
      check_eq("busy",      int'(BUSY), (k < done_e) ? 1 : 0);
      check_eq("done_pls",  int'(DONE_PLS), (k == done_e) ? 1 : 0);
      check_eq("ready",     int'(CMD_READY), (k >= done_e) ? 1 : 0);
      check_eq("steps_done", int'(STEPS_DONE), exp_sd);
      check_eq("err_timeout", int'(ERR_TIMEOUT), (tmo && k >= done_e) ? 1 : 0);
      check_eq("select",    int'(PLL_PHASECOUNTERSELECT), ctr);
      check_eq("updown",    int'(PLL_PHASEUPDOWN), ud);
    end
    CMD_VALID = 1'b0;
    @(posedge CLK50M); #1;
    @(negedge CLK50M);
    check_eq("done_after", int'(DONE_PLS), 0);
    check_eq("busy_after", int'(BUSY), 0);
    check_eq("err_hold", int'(ERR_TIMEOUT), tmo ? 1 : 0);
    check_eq("sdone_hold", int'(STEPS_DONE), ncomp);
  endtask

  task automatic gap_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge CLK50M);
    @(posedge CLK50M); #1;
  endtask

  initial begin
    int steps, stuck;
    repeat (3) @(posedge CLK50M);
    #1;
    RESET = 1'b0;
    @(negedge CLK50M);
    check_idle_outputs("reset");
    @(posedge CLK50M); #1;
    @(negedge CLK50M);
    check_idle_outputs("idle");

    gap_cycles(0);
    run_cmd(3, 1, 1, 1, 2, 4, 1'b0, 1'b0);
    gap_cycles(1);
    run_cmd(int'($urandom_range(0, 15)), 0, 5, 5, 0, 0, 1'b1, 1'b0);
    gap_cycles(0);
    run_cmd(9, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    gap_cycles(2);
    run_cmd(5, 0, 4, 2, 0, 0, 1'b0, 1'b0);
    gap_cycles(0);
    run_cmd(6, 1, 2, 2, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      steps = int'($urandom_range(0, 6));
      stuck = steps;
      if (steps > 0 && $urandom_range(0, 4) == 0) stuck = int'($urandom_range(0, steps - 1));
      gap_cycles(int'($urandom_range(0, 3)));
      run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), steps, stuck,
              0, 0, 1'b0, 1'b0);
    end

    gap_cycles(1);
    run_cmd(12, 1, 3, 3, 0, 0, 1'b0, 1'b1);
    gap_cycles(0);
    run_cmd(10, 0, 2, 2, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
